vid_fetch_ctrl: RTL
===================

// Module: vid_fetch_ctrl
// PURPOSE
//  Pixel-fetch scheduler for the video controller. Walks the frame buffer from base_address,
//  issues 4-beat memory read bursts on the shared bus when the pixel FIFO has room, and
//  writes returned RGB words into the FIFO. Sits between the register file (base/lineinc/
//  hsize/vsize) and the R/G/B FIFO bank that the display timing logic drains.
// PARAMETERS
//  FIFO_DEPTH  16       entries per colour FIFO; the request threshold is derived from this
//  BURST_LEN   4        beats per read burst; each beat is one pixel word
//  REQ_PRI     2'b01    bid value driven on reqout while requesting the bus
// PORTS
//  clk          in   1   single clock
//  reset        in   1   asynchronous, active-high reset
//  en           in   1   controller enable (cr[3])
//  frame_start  in   1   1-cycle pulse at vblank end; starts a frame fetch
//  base_address in   32  byte address of pixel (0,0)
//  lineinc      in   32  byte stride between line starts
//  hsize        in   13  displayed pixels per line
//  vsize        in   13  displayed lines per frame
//  fifo_level   in   5   current FIFO occupancy, 0..16
//  selin        in   1   bus select for incoming beats
//  cmdin        in   3   bus command in; 3'b011 = read data beat
//  addrdatain   in   32  read data; pixel = [23:16] R, [15:8] G, [7:0] B
//  ackin        in   1   bus grant
//  reqout       out  2   bus bid
//  cmdout       out  3   bus command out (3'b010 read, 3'b000 idle)
//  lenout       out  2   burst length code (2'b01 = 4 beats)
//  reqtar       out  4   target select (4'b0000 = memory)
//  addrdataout  out  32  burst start address
//  fifo_wr      out  1   FIFO write strobe (all three colour FIFOs)
//  fifo_wdata   out  24  {R,G,B} to FIFOs
//  frame_done   out  1   1-cycle pulse after the last burst of a frame
//  busy         out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FSM = IDLE, all counters 0. Reset mid-burst aborts the burst;
//  bus outputs drop to 0 asynchronously.
//  hsize_eff = {hsize[12:2],2'b00}. If hsize_eff==0 or vsize==0, the frame is not fetched.
//  FSM states (registered outputs):
//   IDLE : when en && frame_start && hsize_eff!=0 && vsize!=0: line_addr = pix_addr =
//          base_address, pix_cnt = 0, line_cnt = 0 -> FILL. Otherwise stay.
//   FILL : if !en -> IDLE. Else if fifo_level <= FIFO_DEPTH-BURST_LEN -> REQ. Else wait.
//   REQ  : reqout = REQ_PRI. On ackin==1 -> ADDR.
//   ADDR : one cycle: cmdout = 010, lenout = 01, reqtar = 0000, addrdataout = pix_addr,
//          reqout = 0 -> DATA. The cycle after ADDR, cmdout returns to 000.
//   DATA : each cycle with selin && cmdin==011: fifo_wdata = addrdatain[23:0], fifo_wr = 1
//          on the next cycle (latency 1), beat++, pix_addr += 4. Other commands or selin=0
//          are ignored; the FSM has no timeout. After BURST_LEN beats: pix_cnt += 4;
//          pix_cnt==hsize_eff -> LINE, else -> FILL.
//   LINE : line_addr += lineinc; pix_addr = line_addr + lineinc; pix_cnt = 0; line_cnt++.
//          If line_cnt+1==vsize: pulse frame_done -> IDLE. Else -> FILL.
//  Only one burst is outstanding; the threshold check guarantees 4 free FIFO entries.
//  en deassert: takes effect only in FILL/IDLE; an in-flight burst always completes.
//  frame_start outside IDLE is ignored and does not restart the frame.
//  Address arithmetic is modulo 2^32; it wraps silently.
//  Beats received outside DATA are dropped and never written to the FIFO.
//  The config inputs are sampled live; software changes them only while busy==0.
// STRUCTURE
//  vid_pkg: typedef enum {IDLE,FILL,REQ,ADDR,DATA,LINE} fetch_state_t; CMD_READ=3'b010,
//   CMD_RDATA=3'b011, CMD_IDLE=3'b000, LEN_4=2'b01, TAR_MEM=4'b0000.
//  Sub-module vid_fetch_addr_gen holds pix_addr/line_addr/pix_cnt/line_cnt and exposes the
//  line_end/frame_end flags. The FSM and bus drive logic are in this module.
// TESTING
//  1 base=0x1000, lineinc=0x40, hsize=8, vsize=2, fifo_level=0, one ackin per REQ ->
//    read bursts at 0x1000, 0x1010, 0x1040, 0x1050; 16 fifo_wr; frame_done once; IDLE.
//  2 fifo_level=13 in FILL -> no REQ; drop to 12 -> reqout=01 on the next cycle.
//  3 ackin withheld 20 cycles -> reqout held at 01, cmdout stays 000; ackin -> single ADDR
//    cycle with cmdout=010, lenout=01.
//  4 Beat with data 0x00A1B2C3 -> fifo_wr=1 and fifo_wdata=0xA1B2C3 one cycle later;
//    cmdin=001 beats in DATA -> no fifo_wr.
//  5 reset asserted after beat 2 -> outputs 0 immediately, busy=0; the next frame_start
//    refetches from base_address.
//  6 hsize=6 -> hsize_eff=4, one burst per line; hsize=3 or vsize=0 -> frame_start ignored.

Source files
------------

// File: rtl/vid_pkg.sv
// Shared types and bus encodings for the video pixel-fetch path.
package vid_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        REQ  = 3'd2,
        ADDR = 3'd3,
        DATA = 3'd4,
        LINE = 3'd5
    } fetch_state_t;

    localparam logic [2:0] CMD_IDLE  = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b010;
    localparam logic [2:0] CMD_RDATA = 3'b011;
    localparam logic [1:0] LEN_4     = 2'b01;
    localparam logic [3:0] TAR_MEM   = 4'b0000;

    // Line width rounded down to whole bursts of four pixels.
    function automatic logic [12:0] eff_hsize(input logic [12:0] h);
        return h & 13'h1FFC;
    endfunction

endpackage

// File: rtl/vid_fetch_addr_gen.sv
// Frame-buffer walker: current burst address, line start address and
// pixel/line counters, plus end-of-line / end-of-frame flags for the FSM.
module vid_fetch_addr_gen
    import vid_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        beat,
    input  logic        burst_done,
    input  logic        line_step,
    input  logic [31:0] base_address,
    input  logic [31:0] lineinc,
    input  logic [12:0] hsize_eff,
    input  logic [12:0] vsize,
    output logic [31:0] pix_addr,
    output logic        line_end,
    output logic        frame_end
);

    logic [31:0] pix_addr_r;
    logic [31:0] line_addr_r;
    logic [12:0] pix_cnt_r;
    logic [12:0] line_cnt_r;

    // Address and counter update; beats and line steps never coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_addr_r  <= 32'h0;
            line_addr_r <= 32'h0;
            pix_cnt_r   <= 13'd0;
            line_cnt_r  <= 13'd0;
        end else if (start) begin
            pix_addr_r  <= base_address;
            line_addr_r <= base_address;
            pix_cnt_r   <= 13'd0;
            line_cnt_r  <= 13'd0;
        end else if (line_step) begin
            line_addr_r <= line_addr_r + lineinc;
            pix_addr_r  <= line_addr_r + lineinc;
            pix_cnt_r   <= 13'd0;
            line_cnt_r  <= line_cnt_r + 13'd1;
        end else begin
            if (beat) begin
                pix_addr_r <= pix_addr_r + 32'd4;
            end else begin
                pix_addr_r <= pix_addr_r;
            end
            if (burst_done) begin
                pix_cnt_r <= pix_cnt_r + 13'(BURST_LEN);
            end else begin
                pix_cnt_r <= pix_cnt_r;
            end
        end
    end

    // The flags look ahead: true while the burst/line that is finishing is the last one.
    assign pix_addr  = pix_addr_r;
    assign line_end  = ({1'b0, pix_cnt_r} + 14'(BURST_LEN)) == {1'b0, hsize_eff};
    assign frame_end = ({1'b0, line_cnt_r} + 14'd1) == {1'b0, vsize};

endmodule

// File: rtl/vid_fetch_ctrl.sv
// Pixel-fetch scheduler: requests 4-beat read bursts when the colour FIFOs
// have room and forwards returned RGB beats into them, line by line.
module vid_fetch_ctrl
    import vid_pkg::*;
#(
    parameter int         FIFO_DEPTH = 16,
    parameter int         BURST_LEN  = 4,
    parameter logic [1:0] REQ_PRI    = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        frame_start,
    input  logic [31:0] base_address,
    input  logic [31:0] lineinc,
    input  logic [12:0] hsize,
    input  logic [12:0] vsize,
    input  logic [4:0]  fifo_level,
    input  logic        selin,
    input  logic [2:0]  cmdin,
    input  logic [31:0] addrdatain,
    input  logic        ackin,
    output logic [1:0]  reqout,
    output logic [2:0]  cmdout,
    output logic [1:0]  lenout,
    output logic [3:0]  reqtar,
    output logic [31:0] addrdataout,
    output logic        fifo_wr,
    output logic [23:0] fifo_wdata,
    output logic        frame_done,
    output logic        busy
);

    localparam logic [4:0] REQ_THRESH = 5'(FIFO_DEPTH - BURST_LEN);
    localparam int         BCW        = $clog2(BURST_LEN);
    localparam logic [BCW-1:0] BEAT_LAST = BCW'(BURST_LEN - 1);

    fetch_state_t   state_r;
    fetch_state_t   state_nx;
    logic [BCW-1:0] beat_cnt_r;
    logic           start_s;
    logic           beat_s;
    logic           burst_done_s;
    logic           line_step_s;
    logic           frame_done_nx_s;
    logic           rdata_s;
    logic [12:0]    hsize_eff_s;
    logic [31:0]    pix_addr_s;
    logic           line_end_s;
    logic           frame_end_s;
    logic           unused_hi_s;

    logic [1:0]  reqout_r;
    logic [2:0]  cmdout_r;
    logic [1:0]  lenout_r;
    logic [3:0]  reqtar_r;
    logic [31:0] addrdataout_r;
    logic        fifo_wr_r;
    logic [23:0] fifo_wdata_r;
    logic        frame_done_r;
    logic        busy_r;

    assign hsize_eff_s = eff_hsize(hsize);
    assign rdata_s     = selin && (cmdin == CMD_RDATA);
    assign unused_hi_s = ^addrdatain[31:24];

    vid_fetch_addr_gen #(
        .BURST_LEN (BURST_LEN)
    ) u_addr_gen (
        .clk          (clk),
        .reset        (reset),
        .start        (start_s),
        .beat         (beat_s),
        .burst_done   (burst_done_s),
        .line_step    (line_step_s),
        .base_address (base_address),
        .lineinc      (lineinc),
        .hsize_eff    (hsize_eff_s),
        .vsize        (vsize),
        .pix_addr     (pix_addr_s),
        .line_end     (line_end_s),
        .frame_end    (frame_end_s)
    );

    // Next-state decode and per-cycle strobes for the address generator.
    always_comb begin
        state_nx        = state_r;
        start_s         = 1'b0;
        beat_s          = 1'b0;
        burst_done_s    = 1'b0;
        line_step_s     = 1'b0;
        frame_done_nx_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (en && frame_start && (hsize_eff_s != 13'd0) && (vsize != 13'd0)) begin
                    start_s  = 1'b1;
                    state_nx = FILL;
                end else begin
                    state_nx = IDLE;
                end
            end
            FILL: begin
                if (!en) begin
                    state_nx = IDLE;
                end else if (fifo_level <= REQ_THRESH) begin
                    state_nx = REQ;
                end else begin
                    state_nx = FILL;
                end
            end
            REQ: begin
                if (ackin) begin
                    state_nx = ADDR;
                end else begin
                    state_nx = REQ;
                end
            end
            ADDR: begin
                state_nx = DATA;
            end
            DATA: begin
                // No timeout: the burst is owned until every beat has arrived.
                if (rdata_s) begin
                    beat_s = 1'b1;
                    if (beat_cnt_r == BEAT_LAST) begin
                        burst_done_s = 1'b1;
                        state_nx     = line_end_s ? LINE : FILL;
                    end else begin
                        state_nx = DATA;
                    end
                end else begin
                    state_nx = DATA;
                end
            end
            LINE: begin
                line_step_s = 1'b1;
                if (frame_end_s) begin
                    frame_done_nx_s = 1'b1;
                    state_nx        = IDLE;
                end else begin
                    state_nx = FILL;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register and beat counter within the current burst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            beat_cnt_r <= '0;
        end else begin
            state_r <= state_nx;
            if (start_s) begin
                beat_cnt_r <= '0;
            end else if (beat_s) begin
                beat_cnt_r <= beat_cnt_r + BCW'(1);
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end
        end
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reqout_r      <= 2'b00;
            cmdout_r      <= CMD_IDLE;
            lenout_r      <= 2'b00;
            reqtar_r      <= 4'b0000;
            addrdataout_r <= 32'h0;
            fifo_wr_r     <= 1'b0;
            fifo_wdata_r  <= 24'h0;
            frame_done_r  <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            reqout_r      <= (state_nx == REQ)  ? REQ_PRI    : 2'b00;
            cmdout_r      <= (state_nx == ADDR) ? CMD_READ   : CMD_IDLE;
            lenout_r      <= (state_nx == ADDR) ? LEN_4      : 2'b00;
            reqtar_r      <= TAR_MEM;
            addrdataout_r <= (state_nx == ADDR) ? pix_addr_s : 32'h0;
            fifo_wr_r     <= beat_s;
            fifo_wdata_r  <= beat_s ? addrdatain[23:0] : fifo_wdata_r;
            frame_done_r  <= frame_done_nx_s;
            busy_r        <= (state_nx != IDLE);
        end
    end

    assign reqout      = reqout_r;
    assign cmdout      = cmdout_r;
    assign lenout      = lenout_r;
    assign reqtar      = reqtar_r;
    assign addrdataout = addrdataout_r;
    assign fifo_wr     = fifo_wr_r;
    assign fifo_wdata  = fifo_wdata_r;
    assign frame_done  = frame_done_r;
    assign busy        = busy_r;

endmodule
